// File: rtl/pc_gen_unit_pkg.sv
// Shared types and constants for the program-counter generator:
// FSM state encoding, default vectors and next-PC source select.
package pc_gen_unit_pkg;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } pc_state_e;

   typedef enum logic [2:0] {
      SEL_HOLD     = 3'd0,
      SEL_TRAP     = 3'd1,
      SEL_MRET     = 3'd2,
      SEL_REDIRECT = 3'd3,
      SEL_MISALIGN = 3'd4,
      SEL_SEQ      = 3'd5
   } pc_sel_e;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Control and fetch-port bundle of the PC generator; slave is the unit's view.
// fetch_valid/fetch_ready: a fetch is accepted on a rising edge where both are high and stall is low.
interface pc_gen_unit_if #(
   parameter int PC_WIDTH  = 32,
   parameter int CNT_WIDTH = 32
);
   import pc_gen_unit_pkg::*;

   logic                 fetch_ready;
   logic                 stall;
   logic                 redirect_valid;
   logic [PC_WIDTH-1:0]  redirect_target;
   logic                 trap_req;
   logic [PC_WIDTH-1:0]  trap_pc;
   logic                 mret;
   logic                 halt_req;
   logic                 resume;
   logic [PC_WIDTH-1:0]  PC;
   logic                 fetch_valid;
   logic [PC_WIDTH-1:0]  epc;
   logic                 misalign_trap;
   logic                 halted;
   logic [CNT_WIDTH-1:0] fetch_count;
   pc_state_e            state_dbg;

   modport slave (
      input  fetch_ready, stall, redirect_valid, redirect_target, trap_req, trap_pc,
             mret, halt_req, resume,
      output PC, fetch_valid, epc, misalign_trap, halted, fetch_count, state_dbg
   );

   modport master (
      output fetch_ready, stall, redirect_valid, redirect_target, trap_req, trap_pc,
             mret, halt_req, resume,
      input  PC, fetch_valid, epc, misalign_trap, halted, fetch_count, state_dbg
   );

endinterface

// File: rtl/pc_gen_unit_pc_next_sel.sv
// Combinational next-PC priority mux: trap > mret > aligned redirect >
// misaligned redirect > sequential fetch > hold.
module pc_next_sel
   import pc_gen_unit_pkg::*;
#(
   parameter int                  PC_WIDTH    = 32,
   parameter int                  PC_STEP     = 4,
   parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = PC_WIDTH'(DEFAULT_TRAP_VECTOR)
) (
   input  logic                trap_req,
   input  logic                mret,
   input  logic                redirect_valid,
   input  logic                fire,
   input  logic [PC_WIDTH-1:0] redirect_target,
   input  logic [PC_WIDTH-1:0] trap_pc,
   input  logic [PC_WIDTH-1:0] pc,
   input  logic [PC_WIDTH-1:0] epc,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic                epc_we,
   output logic [PC_WIDTH-1:0] epc_wdata,
   output logic                misalign,
   output pc_sel_e             sel
);

   always_comb begin
      sel = SEL_HOLD;
      if (trap_req)                                        sel = SEL_TRAP;
      else if (mret)                                       sel = SEL_MRET;
      else if (redirect_valid && redirect_target[1:0] == 2'b00) sel = SEL_REDIRECT;
      else if (redirect_valid)                             sel = SEL_MISALIGN;
      else if (fire)                                       sel = SEL_SEQ;
   end

   always_comb begin
      next_pc   = pc;
      epc_we    = 1'b0;
      epc_wdata = trap_pc;
      misalign  = 1'b0;
      unique case (sel)
         SEL_TRAP: begin
            next_pc = TRAP_VECTOR;
            epc_we  = 1'b1;
         end
         SEL_MRET:     next_pc = epc;
         SEL_REDIRECT: next_pc = redirect_target;
         SEL_MISALIGN: begin
            // The faulting instruction is the one at the current fetch PC.
            next_pc   = TRAP_VECTOR;
            epc_we    = 1'b1;
            epc_wdata = pc;
            misalign  = 1'b1;
         end
         SEL_SEQ:  next_pc = pc + PC_WIDTH'(PC_STEP);
         default:  next_pc = pc;
      endcase
   end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: BOOT/RUN/HALT FSM, PC/EPC registers, misalign pulse
// and accepted-fetch counter; next-PC choice comes from pc_next_sel.
module pc_gen_unit
   import pc_gen_unit_pkg::*;
#(
   parameter int                  PC_WIDTH     = 32,
   parameter int                  PC_STEP      = 4,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEFAULT_RESET_VECTOR),
   parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(DEFAULT_TRAP_VECTOR),
   parameter int                  CNT_WIDTH    = 32
) (
   input  logic         CPU_clk,
   input  logic         CPU_rst_n,
   pc_gen_unit_if.slave bus
);

   pc_state_e            state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [PC_WIDTH-1:0]  epc_q, epc_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 misalign_q, misalign_d;

   logic                 in_run;
   logic                 in_halt;
   logic                 fire;
   logic [PC_WIDTH-1:0]  sel_next_pc;
   logic                 sel_epc_we;
   logic [PC_WIDTH-1:0]  sel_epc_wdata;
   logic                 sel_misalign;
   pc_sel_e              sel_src;

   assign in_run  = (state_q == ST_RUN);
   assign in_halt = (state_q == ST_HALT);
   assign fire    = in_run && bus.fetch_ready && !bus.stall;

   // HALT only honours trap_req; BOOT ignores every source.
   pc_next_sel #(
      .PC_WIDTH    (PC_WIDTH),
      .PC_STEP     (PC_STEP),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_next_sel (
      .trap_req        (bus.trap_req && (in_run || in_halt)),
      .mret            (bus.mret && in_run),
      .redirect_valid  (bus.redirect_valid && in_run),
      .fire            (fire),
      .redirect_target (bus.redirect_target),
      .trap_pc         (bus.trap_pc),
      .pc              (pc_q),
      .epc             (epc_q),
      .next_pc         (sel_next_pc),
      .epc_we          (sel_epc_we),
      .epc_wdata       (sel_epc_wdata),
      .misalign        (sel_misalign),
      .sel             (sel_src)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      epc_d      = epc_q;
      cnt_d      = cnt_q;
      misalign_d = 1'b0;
      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            pc_d       = sel_next_pc;
            misalign_d = sel_misalign;
            if (sel_epc_we) epc_d = sel_epc_wdata;
            if (fire)       cnt_d = cnt_q + CNT_WIDTH'(1);
            if (bus.halt_req && !bus.trap_req) state_d = ST_HALT;
         end
         ST_HALT: begin
            pc_d = sel_next_pc;
            if (sel_epc_we) epc_d = sel_epc_wdata;
            if (bus.trap_req || bus.resume) state_d = ST_RUN;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge CPU_clk) begin
      if (!CPU_rst_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         epc_q      <= '0;
         cnt_q      <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         cnt_q      <= cnt_d;
         misalign_q <= misalign_d;
      end
   end

   assign bus.PC            = pc_q;
   assign bus.fetch_valid   = in_run;
   assign bus.halted        = in_halt;
   assign bus.epc           = epc_q;
   assign bus.fetch_count   = cnt_q;
   assign bus.misalign_trap = misalign_q;
   assign bus.state_dbg     = state_q;

   logic unused_sel;
   assign unused_sel = ^sel_src;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed scenarios then random stimulus,
// checked against a cycle-level behavioural model of the PC rules.
module tb_pc_gen_unit;
   import pc_gen_unit_pkg::*;

   localparam int W = 101;
   localparam logic [31:0] RST_VEC  = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
   localparam int M_BOOT = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic clk;
   logic rst_n;

   pc_gen_unit_if #(.PC_WIDTH(32), .CNT_WIDTH(32)) bus ();

   pc_gen_unit #(
      .PC_WIDTH     (32),
      .PC_STEP      (4),
      .RESET_VECTOR (RST_VEC),
      .TRAP_VECTOR  (TRAP_VEC),
      .CNT_WIDTH    (32)
   ) dut (
      .CPU_clk   (clk),
      .CPU_rst_n (rst_n),
      .bus       (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard state
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_mode = M_BOOT;
   logic [31:0] m_pc   = RST_VEC;
   logic [31:0] m_epc  = 32'h0;
   logic [31:0] m_cnt  = 32'h0;
   logic        m_mis  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of the architectural rules, using the inputs held across the edge.
   task automatic model_step();
      logic        fire;
      logic [31:0] tgt;
      tgt = bus.redirect_target;
      if (!rst_n) begin
         m_mode = M_BOOT; m_pc = RST_VEC; m_epc = 0; m_cnt = 0; m_mis = 0;
      end else begin
         fire  = (m_mode == M_RUN) && bus.fetch_ready && !bus.stall;
         m_mis = 1'b0;
         if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
         end else if (m_mode == M_HALT) begin
            if (bus.trap_req) begin
               m_pc = TRAP_VEC; m_epc = bus.trap_pc; m_mode = M_RUN;
            end else if (bus.resume) begin
               m_mode = M_RUN;
            end
         end else begin
            if (fire) m_cnt = m_cnt + 1;
            if (bus.trap_req) begin
               m_pc = TRAP_VEC; m_epc = bus.trap_pc;
            end else if (bus.mret) begin
               m_pc = m_epc;
            end else if (bus.redirect_valid && (tgt % 4 == 0)) begin
               m_pc = tgt;
            end else if (bus.redirect_valid) begin
               m_epc = m_pc; m_pc = TRAP_VEC; m_mis = 1'b1;
            end else if (fire) begin
               m_pc = m_pc + 4;
            end
            if (bus.halt_req && !bus.trap_req) m_mode = M_HALT;
         end
      end
   endtask

   // driver tasks
   task automatic step();
      logic [1:0] st;
      @(posedge clk);
      model_step();
      st = 2'(m_mode);
      exp_q.push_back({st, m_pc, m_epc, m_cnt, (m_mode == M_RUN), (m_mode == M_HALT), m_mis});
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic idle();
      rst_n = 1'b1;
      bus.fetch_ready = 1'b1; bus.stall = 1'b0;
      bus.redirect_valid = 1'b0; bus.redirect_target = 32'h0;
      bus.trap_req = 1'b0; bus.trap_pc = 32'h0; bus.mret = 1'b0;
      bus.halt_req = 1'b0; bus.resume = 1'b0;
   endtask

   task automatic redirect(input logic [31:0] tgt);
      bus.redirect_valid = 1'b1; bus.redirect_target = tgt;
      step();
      bus.redirect_valid = 1'b0;
   endtask

   // monitor: compare every presented output set against the oldest expectation
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",         32'(bus.state_dbg),     32'(e[100:99]));
            check("pc",            bus.PC,                 e[98:67]);
            check("epc",           bus.epc,                e[66:35]);
            check("fetch_count",   bus.fetch_count,        e[34:3]);
            check("fetch_valid",   32'(bus.fetch_valid),   32'(e[2]));
            check("halted",        32'(bus.halted),        32'(e[1]));
            check("misalign_trap", 32'(bus.misalign_trap), 32'(e[0]));
         end
      end
   end

   initial begin
      int r;
      idle();
      rst_n = 1'b0;
      // reset and boot
      steps(3);
      rst_n = 1'b1;
      steps(5);
      // stall then back-pressure at 0x10
      redirect(32'h10);
      bus.stall = 1'b1; steps(2);
      bus.stall = 1'b0; bus.fetch_ready = 1'b0; steps(2);
      bus.fetch_ready = 1'b1; steps(2);
      // redirect under stall, aligned then misaligned
      redirect(32'h20);
      bus.stall = 1'b1; redirect(32'h80); bus.stall = 1'b0; step();
      redirect(32'h20);
      bus.stall = 1'b1; redirect(32'h82); bus.stall = 1'b0; steps(2);
      // trap and mret together, then lone mret
      bus.trap_req = 1'b1; bus.trap_pc = 32'h44; bus.mret = 1'b1; step();
      bus.trap_req = 1'b0; bus.mret = 1'b0; steps(2);
      bus.mret = 1'b1; step(); bus.mret = 1'b0; step();
      // halt at 0x30, resume, halt again and leave via trap
      redirect(32'h30);
      bus.fetch_ready = 1'b0; bus.halt_req = 1'b1; step();
      bus.halt_req = 1'b0; bus.fetch_ready = 1'b1; steps(5);
      bus.resume = 1'b1; step(); bus.resume = 1'b0; steps(2);
      bus.halt_req = 1'b1; step(); bus.halt_req = 1'b0; steps(2);
      bus.trap_req = 1'b1; bus.trap_pc = 32'h50; step(); bus.trap_req = 1'b0; step();
      // halt_req with trap_req: trap wins, stays in RUN
      bus.halt_req = 1'b1; bus.trap_req = 1'b1; bus.trap_pc = 32'h60; step();
      idle(); step();
      // wrap, then reset with a redirect pending
      redirect(32'hFFFF_FFFC);
      steps(2);
      bus.redirect_valid = 1'b1; bus.redirect_target = 32'h40; rst_n = 1'b0; step();
      idle(); steps(4);

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         rst_n              = ($urandom_range(0, 199) != 0);
         bus.fetch_ready    = ($urandom_range(0, 3) != 0);
         bus.stall          = ($urandom_range(0, 4) == 0);
         bus.trap_req       = ($urandom_range(0, 24) == 0);
         bus.trap_pc        = $urandom;
         bus.mret           = ($urandom_range(0, 19) == 0);
         bus.redirect_valid = ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 9);
         if (r < 2)       bus.redirect_target = $urandom;
         else if (r == 2) bus.redirect_target = 32'hFFFF_FFFC;
         else             bus.redirect_target = 32'($urandom_range(0, 255)) << 2;
         bus.halt_req       = ($urandom_range(0, 29) == 0);
         bus.resume         = ($urandom_range(0, 3) == 0);
         step();
      end
      idle();
      steps(2);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
Parametrised next-generation program counter for the RV32IM core. It holds the fetch PC and selects the next PC from four sources: sequential, branch/jump redirect, trap entry, and trap return. It drives a valid/ready fetch handshake toward instruction memory, and it traps misaligned redirect targets. It keeps an exception-PC (EPC) register and a fetch counter, and it sits between the control/branch unit and the instruction-fetch port.

Parameters:
PC_WIDTH, 32, width of PC, targets, EPC
PC_STEP, 4, sequential increment in bytes
RESET_VECTOR, 32'h0000_0000, PC value held from reset onwards
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry
CNT_WIDTH, 32, width of fetch counter

Ports:
CPU_clk  input  1  core clock, all state updates on rising edge
CPU_rst_n  input  1  synchronous active-low reset
fetch_ready  input  1  instruction memory accepts current PC
stall  input  1  hazard stall; PC held
redirect_valid  input  1  branch taken / jump this cycle
redirect_target  input  PC_WIDTH  branch/jump target
trap_req  input  1  external/illegal-instruction trap request
trap_pc  input  PC_WIDTH  PC of trapping instruction
mret  input  1  return from trap
halt_req  input  1  enter HALT (ebreak/debug)
resume  input  1  leave HALT
PC  output  PC_WIDTH  current fetch address
fetch_valid  output  1  PC is a valid fetch request
epc  output  PC_WIDTH  saved exception PC
misalign_trap  output  1  one-cycle pulse: redirect target misaligned
halted  output  1  unit is in HALT
fetch_count  output  CNT_WIDTH  number of accepted fetches

Behaviour:
- One clock, CPU_clk. Reset is synchronous and active-low on CPU_rst_n, sampled only on the rising edge of CPU_clk.
- Reset values: PC=RESET_VECTOR, epc=0, fetch_count=0, misalign_trap=0, halted=0, fetch_valid=0, state=BOOT.
- No pre-decrement trick: PC equals RESET_VECTOR while in reset.
- State machine:
  - BOOT: fetch_valid=0 for exactly one cycle after reset is released, then go to RUN. PC is unchanged.
  - RUN: fetch_valid=1.
  - HALT: fetch_valid=0 and halted=1. PC is frozen; only trap_req and reset are honoured. On resume, go to RUN with PC unchanged.
- RUN to HALT: on halt_req, unless trap_req is asserted the same cycle (trap wins and the unit stays in RUN). The PC update rules still apply in that cycle.
- Fire is defined as fetch_valid && fetch_ready && !stall.
- Next-PC priority in RUN, highest first:
  1. trap_req: PC<=TRAP_VECTOR, epc<=trap_pc.
  2. mret: PC<=epc.
  3. redirect_valid with redirect_target[1:0]==0: PC<=redirect_target.
  4. redirect_valid with target misaligned: PC<=TRAP_VECTOR, epc<=PC, misalign_trap=1 for the next cycle only.
  5. fire: PC<=PC+PC_STEP, modulo 2^PC_WIDTH, so the PC wraps from max to 0.
  6. Otherwise hold.
- Sources 1-4 act regardless of stall and fetch_ready; a redirect never waits for the handshake.
- trap_req in HALT: PC<=TRAP_VECTOR, epc<=trap_pc, state returns to RUN.
- fetch_count increments by 1 on each fire (any fire, including the fire cycle of a redirect), wraps at 2^CNT_WIDTH, and never saturates.
- Simultaneous trap_req and mret: trap wins; epc takes trap_pc, not the old value.
- Reset asserted mid-operation: all state returns to its reset values on the next edge, the in-flight redirect is discarded, and BOOT repeats.
- fetch_valid is registered from state only; there is no combinational path from the inputs to fetch_valid or PC.

Decomposition:
- Shared package/header: state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), the default RESET_VECTOR and TRAP_VECTOR constants, and the next-PC select encoding.
- One natural sub-module: pc_next_sel. It is a combinational priority mux producing next_pc, the epc write enable/data, and the misalign flag. The top module keeps the registers, FSM and counter.

Test Plan:
1. Reset and boot: hold CPU_rst_n=0 for 3 cycles with fetch_ready=1, then release. Expect PC=0 and fetch_valid=0 for 1 cycle, then PC=0,4,8,… each cycle and fetch_count=1,2,3.
2. Stall and back-pressure: in RUN at PC=0x10, stall=1 for 2 cycles, then fetch_ready=0 for 2 cycles. Expect PC held at 0x10 for all 4 cycles and fetch_count unchanged; then 0x14 on the next fire.
3. Redirect under stall: PC=0x20, stall=1, redirect_valid=1 with target 0x80. Expect PC=0x80 on the next edge and fetch_count unchanged. Repeat with target 0x82: expect PC=0x100, epc=0x20, misalign_trap pulsed for 1 cycle.
4. Trap/mret priority: trap_req=1 with trap_pc=0x44 and mret=1 in the same cycle. Expect PC=0x100, epc=0x44. A later lone mret gives PC=0x44.
5. Halt: halt_req at PC=0x30. Expect halted=1, fetch_valid=0, PC frozen at 0x30 for 5 cycles. resume returns to RUN at 0x30. A second halt followed by trap_req gives PC=0x100, halted=0.
6. Wrap and mid-run reset: force PC to 0xFFFF_FFFC via redirect, then fire. Expect PC=0. Assert CPU_rst_n=0 while a redirect is pending: expect PC=0, epc=0, fetch_count=0, and BOOT repeated.
